// File: rtl/sha256_sched_feeder.sv
// Batches up to four 512-bit blocks, drives the 4-way interleaved SHA-256 schedule
// expander, and merges raw W0..W15 with expanded W16..W63 into one tagged W stream.
module sha256_sched_feeder #(
    parameter int NMSG    = 4,
    parameter int EXP_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    output logic [31:0] exp_data_o,
    output logic        exp_send_o,
    input  logic [31:0] exp_data_i,
    output logic        w_valid_o,
    output logic [31:0] w_o,
    output logic [1:0]  w_msg_o,
    output logic [5:0]  w_round_o,
    output logic        w_last_o,
    output logic        done_o
);
    localparam int DW = (EXP_LAT > 1) ? $clog2(EXP_LAT) : 1;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    typedef struct packed {
        logic        vld;
        logic [1:0]  msg;
        logic [5:0]  rnd;
        logic        lst;
        logic [31:0] raw;
    } slot_t;

    state_t          state, state_nx;
    logic [5:0]      ld_cnt;
    logic [2:0]      nmsg;
    logic [7:0]      t;
    logic [DW-1:0]   dr_cnt;
    logic [31:0]     mem [64];

    logic            accept, ld_end, dr_last, slot_vld;
    logic [1:0]      m;
    logic [5:0]      j;
    logic [31:0]     raw;
    slot_t           cur;

    assign m        = t[1:0];
    assign j        = t[7:2];
    assign accept   = in_valid_i && (state == LOAD);
    assign ld_end   = accept && (ld_cnt[3:0] == 4'hf) &&
                      (in_last_i || (ld_cnt[5:4] == 2'(NMSG - 1)));
    assign dr_last  = (state == DRAIN) && (dr_cnt == DW'(EXP_LAT - 1));
    assign slot_vld = (state == RUN) && ({1'b0, m} < nmsg);
    assign raw      = mem[{m, j[3:0]}];

    always_ff @(posedge clk_i) begin
        if (accept) mem[ld_cnt] <= in_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= LOAD;
            ld_cnt <= '0;
            nmsg   <= '0;
            t      <= '0;
            dr_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: if (accept) begin
                    ld_cnt <= ld_cnt + 6'd1;
                    if (ld_end) begin
                        ld_cnt <= '0;
                        nmsg   <= {1'b0, ld_cnt[5:4]} + 3'd1;
                        t      <= '0;
                    end
                end
                RUN: t <= t + 8'd1;
                DRAIN: begin
                    dr_cnt <= dr_cnt + DW'(1);
                    if (dr_last) begin
                        dr_cnt <= '0;
                        ld_cnt <= '0;
                        nmsg   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready_o = 1'b0;
        exp_send_o = 1'b0;
        exp_data_o = '0;
        done_o     = 1'b0;
        case (state)
            LOAD: begin
                in_ready_o = 1'b1;
                if (ld_end) state_nx = RUN;
            end
            RUN: begin
                // First 64 slots overwrite the whole expander chain; absent messages get zeros.
                if (t[7:6] == 2'd0) begin
                    if (slot_vld) exp_data_o = raw;
                end else begin
                    exp_send_o = 1'b1;
                end
                if (t == 8'hff) state_nx = DRAIN;
            end
            DRAIN: begin
                if (dr_last) begin
                    done_o   = 1'b1;
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        cur = '0;
        if (slot_vld) begin
            cur.vld = 1'b1;
            cur.msg = m;
            cur.rnd = j;
            cur.lst = (j == 6'd63) && ({1'b0, m} == nmsg - 3'd1);
            cur.raw = raw;
        end
    end

    // Tags and raw words ride the pipeline; the expander word is taken at the last stage.
    for (genvar k = 0; k < EXP_LAT; k++) begin : g_pipe
        slot_t src, d, q;
        if (k == 0) begin : g_first
            assign src = cur;
        end else begin : g_next
            assign src = g_pipe[k-1].q;
        end

        always_comb begin
            d = src;
            if ((k == EXP_LAT - 1) && src.vld && (src.rnd[5:4] != 2'd0)) d.raw = exp_data_i;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) q <= '0;
            else       q <= d;
        end
    end

    assign w_valid_o = g_pipe[EXP_LAT-1].q.vld;
    assign w_msg_o   = g_pipe[EXP_LAT-1].q.msg;
    assign w_round_o = g_pipe[EXP_LAT-1].q.rnd;
    assign w_last_o  = g_pipe[EXP_LAT-1].q.lst;
    assign w_o       = g_pipe[EXP_LAT-1].q.raw;
endmodule

// File: tb/tb_sha256_sched_feeder.sv
// Random batches through the feeder with a behavioural 4-way expander attached;
// the W stream is checked against a per-message SHA-256 schedule computed directly.
module tb_sha256_sched_feeder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last;
    logic [31:0] in_data, exp_data_o, exp_data_i, w;
    logic        exp_send, w_valid, w_last, done;
    logic [1:0]  w_msg;
    logic [5:0]  w_round;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_sched_feeder dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .exp_data_o(exp_data_o), .exp_send_o(exp_send), .exp_data_i(exp_data_i),
        .w_valid_o(w_valid), .w_o(w), .w_msg_o(w_msg), .w_round_o(w_round),
        .w_last_o(w_last), .done_o(done)
    );

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // External expander: 64-deep chain, four messages interleaved, so W[j-k] of the
    // same message sits 4k slots back.
    logic [31:0] ch [64];
    logic [31:0] exp_new;
    assign exp_new    = ss1(ch[7]) + ch[27] + ss0(ch[59]) + ch[63];
    assign exp_data_i = exp_send ? exp_new : ch[63];
    always @(posedge clk) begin
        for (int i = 63; i > 0; i--) ch[i] <= ch[i-1];
        ch[0] <= exp_send ? exp_new : exp_data_o;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] abc_word(input int i);
        if (i == 0)  return 32'h61626380;
        if (i == 15) return 32'h00000018;
        return 32'h0;
    endfunction

    function automatic logic [31:0] abc_known(input int r);
        case (r)
            16:      return 32'h61626380;
            17:      return 32'h000F0000;
            18:      return 32'h7DA86405;
            default: return 32'h12B1EDEB;
        endcase
    endfunction

    logic [31:0] blk [4][16];
    logic [31:0] rw  [4][64];

    // Entered and left on a negedge; abort_at >= 0 resets the DUT at that RUN slot.
    task automatic batch(input int nb, input bit abc, input bit tog, input bit fin_last,
                         input bit hold, input int abort_at);
        int beat = 0, cyc = 0, nw = nb * 16, nvld = 0, nlast = 0, ndone = 0;
        bit acc;
        for (int mm = 0; mm < 4; mm++)
            for (int i = 0; i < 16; i++)
                blk[mm][i] = (mm < nb) ? (abc ? abc_word(i) : $urandom) : 32'h0;
        for (int mm = 0; mm < 4; mm++) begin
            for (int r = 0; r < 16; r++) rw[mm][r] = blk[mm][r];
            for (int r = 16; r < 64; r++)
                rw[mm][r] = ss1(rw[mm][r-2]) + rw[mm][r-7] + ss0(rw[mm][r-15]) + rw[mm][r-16];
        end

        while (beat < nw) begin
            if (cyc >= 400) begin
                chk("load_timeout", 64'(beat), 64'(nw));
                in_valid = 1'b0;
                return;
            end
            chk("ld_ready", 64'(in_ready), 64'd1);
            in_valid = tog ? ((cyc % 2) == 0) : 1'b1;
            in_data  = blk[beat / 16][beat % 16];
            if (beat == nw - 1) in_last = fin_last;
            else                in_last = ((beat % 16) != 15) && (($urandom % 3) == 0);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) beat++;
            @(negedge clk);
            cyc++;
        end
        in_valid = hold;
        in_last  = 1'b0;
        in_data  = $urandom;

        for (int k = 0; k <= 257; k++) begin
            int s, em, ej, tm, tj;
            bit ev, elast;
            logic [63:0] exp_w, exp_x;
            if (abort_at >= 0 && k == abort_at + 1) begin
                chk("rst_ctl", {60'b0, in_ready, exp_send, w_valid, done}, 64'h8);
                chk("rst_data", {exp_data_o, w}, 64'h0);
                chk("rst_tag", {55'b0, w_msg, w_round, w_last}, 64'h0);
                rst = 1'b0;
                return;
            end
            s     = k - 1;
            em    = (s >= 0) ? s % 4 : 0;
            ej    = (s >= 0) ? s / 4 : 0;
            ev    = (k >= 1) && (k <= 256) && (em < nb);
            elast = ev && (ej == 63) && (em == nb - 1);
            exp_w = '0;
            if (ev) exp_w = {22'b0, 1'b1, 2'(em), 6'(ej), elast, rw[em][ej]};
            chk("wstream", {22'b0, w_valid, w_msg, w_round, w_last, w}, exp_w);
            if (abc && ev && em == 0 && (ej == 16 || ej == 17 || ej == 18 || ej == 63))
                chk("abc_known", 64'(w), 64'(abc_known(ej)));

            tm = k % 4;
            tj = k / 4;
            if (k < 64)       exp_x = {31'b0, 1'b0, (tm < nb) ? blk[tm][tj] : 32'h0};
            else if (k < 256) exp_x = {31'b0, 1'b1, 32'h0};
            else              exp_x = '0;
            chk("exp_if", {31'b0, exp_send, exp_data_o}, exp_x);
            chk("ctl", {62'b0, in_ready, done}, {62'b0, k == 257, k == 256});

            nvld  += int'(w_valid);
            nlast += int'(w_last);
            ndone += int'(done);
            if (k == abort_at) rst = 1'b1;
            if (k < 257) @(negedge clk);
        end
        chk("n_valid", 64'(nvld), 64'(nb * 64));
        chk("n_last", 64'(nlast), 64'd1);
        chk("n_done", 64'(ndone), 64'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {60'b0, in_ready, exp_send, w_valid, done}, 64'h8);
        chk("reset_data", {exp_data_o, w}, 64'h0);
        chk("reset_tag", {55'b0, w_msg, w_round, w_last}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        batch(1, 1'b1, 1'b0, 1'b1, 1'b0, -1);   // single "abc"
        batch(4, 1'b1, 1'b0, 1'b0, 1'b1, -1);   // four "abc", 64th-beat end, valid held in RUN
        batch(2, 1'b0, 1'b0, 1'b1, 1'b0, -1);   // two blocks
        batch(4, 1'b0, 1'b1, 1'b1, 1'b1, -1);   // toggled load valid
        batch(3, 1'b0, 1'b0, 1'b1, 1'b1, 100);  // reset mid-RUN
        batch(1, 1'b1, 1'b0, 1'b1, 1'b0, -1);   // fresh "abc" after reset
        repeat (3)
            batch(int'($urandom_range(1, 4)), 1'b0, 1'(($urandom % 2)), 1'b1, 1'(($urandom % 2)), -1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
